// File: rtl/spi_bus_arbiter.sv
// -----------------------------------------------------------------------------
// spi_bus_arbiter
//
// This block lets N_REQ requester FSMs share one SPI engine. Requester 0 is the
// temp sensor, 1 is the adc and 2 is the eink sequencer.
//
// Requests are served in round-robin order. The owner keeps its grant for the
// whole transfer. The engine gets a one-cycle start strobe. The owner gets a
// one-cycle done pulse when the transfer ends. The engine's active-low cs is
// routed to the owner's cs line only.
//
// Ports:
//   clk_in       system clock (all logic on the rising edge)
//   rst_n        asynchronous active-low reset
//   req          level request per requester, held until its done pulse
//   grant        one-hot (or zero) owner grant, high for the whole transfer
//   done         one-cycle end-of-transfer pulse to the owner
//   sel          index of the current owner, held between transfers
//   spi_start    one-cycle start strobe to the engine
//   spi_done_in  engine trans_done (sck domain, synchronized here)
//   spi_cs_in    engine cs, active-low
//   cs_out       per-device active-low cs
//   busy         high whenever the FSM is not idle
//   timeout_err  one-cycle pulse when a transfer is force-released
//
// Optional feature: define SPI_BUS_ARBITER_TIMEOUT_EN to force a release after
// TIMEOUT_CYCLES cycles in WAIT. When the macro is undefined, WAIT never
// times out and timeout_err is tied low.
// -----------------------------------------------------------------------------
module spi_bus_arbiter #(
    parameter int unsigned N_REQ          = 3,
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd1000000,
    parameter int unsigned SYNC_STAGES    = 2,
    localparam int unsigned SEL_W         = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] grant,
    output logic [N_REQ-1:0] done,
    output logic [SEL_W-1:0] sel,
    output logic             spi_start,
    input  logic             spi_done_in,
    input  logic             spi_cs_in,
    output logic [N_REQ-1:0] cs_out,
    output logic             busy,
    output logic             timeout_err
);

    typedef enum logic [2:0] {StIdle, StGrant, StStart, StWait, StRelease} state_e;

    state_e                 state_q, state_d;
    logic [N_REQ-1:0]       grant_q, grant_d;
    logic [SEL_W-1:0]       sel_q, sel_d;
    logic [SEL_W-1:0]       ptr_q, ptr_d;
    logic                   start_q;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   done_sync;
    logic                   done_prev_q;
    logic                   done_edge_q;
    logic                   pick_valid;
    logic [SEL_W-1:0]       pick_idx;
    logic [SEL_W-1:0]       scan_idx;
    logic                   timeout_hit;

    assign done_sync = sync_q[SYNC_STAGES-1];

    // Scan from the requester after the last owner, wrapping around.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        scan_idx   = '0;
        for (int k = 1; k <= int'(N_REQ); k++) begin
            scan_idx = SEL_W'((int'(ptr_q) + k) % int'(N_REQ));
            if (!pick_valid && req[scan_idx]) begin
                pick_valid = 1'b1;
                pick_idx   = scan_idx;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        case (state_q)
            StIdle: begin
                if (pick_valid) begin
                    for (int i = 0; i < int'(N_REQ); i++) begin
                        grant_d[i] = (pick_idx == SEL_W'(i));
                    end
                    sel_d   = pick_idx;
                    state_d = StGrant;
                end
            end
            StGrant:   state_d = StStart;
            StStart:   state_d = StWait;
            StWait: begin
                if (done_edge_q || timeout_hit) begin
                    state_d = StRelease;
                end
            end
            StRelease: begin
                grant_d = '0;
                ptr_d   = sel_q;
                state_d = StIdle;
            end
            default:   state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            grant_q     <= '0;
            sel_q       <= '0;
            ptr_q       <= SEL_W'(N_REQ - 1);
            start_q     <= 1'b0;
            sync_q      <= '0;
            done_prev_q <= 1'b0;
            done_edge_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            sel_q       <= sel_d;
            ptr_q       <= ptr_d;
            // The strobe is registered, so the engine sees a clean pulse. It is
            // high during the first WAIT cycle.
            start_q     <= (state_q == StStart);
            sync_q      <= {sync_q[SYNC_STAGES-2:0], spi_done_in};
            done_prev_q <= done_sync;
            // Only a rising edge seen while waiting counts. A level left high by
            // an earlier transfer, or a stale edge after reset, is ignored.
            done_edge_q <= (state_q == StWait) && done_sync && !done_prev_q;
        end
    end

`ifdef SPI_BUS_ARBITER_TIMEOUT_EN
    logic [23:0] wait_cnt_q;
    logic        timeout_q;

    assign timeout_hit = (state_q == StWait) && !done_edge_q &&
                         (wait_cnt_q == TIMEOUT_CYCLES - 24'd1);

    // The counter is zero on the first WAIT cycle, because every state
    // before WAIT holds it cleared.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            wait_cnt_q <= (state_q == StWait) ? wait_cnt_q + 24'd1 : '0;
            timeout_q  <= timeout_hit;
        end
    end

    assign timeout_err = timeout_q;
`else
    assign timeout_hit = 1'b0;
    assign timeout_err = 1'b0;
`endif

    assign grant     = grant_q;
    assign sel       = sel_q;
    assign spi_start = start_q;
    assign busy      = (state_q != StIdle);
    // grant_q still holds the owner in RELEASE, so it equals done[sel].
    assign done      = (state_q == StRelease) ? grant_q : '0;

    // grant_q is registered and cleared asynchronously, so non-owners never glitch.
    always_comb begin
        cs_out = '1;
        for (int i = 0; i < int'(N_REQ); i++) begin
            cs_out[i] = grant_q[i] ? spi_cs_in : 1'b1;
        end
    end

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_spi_bus_arbiter
//
// Drives directed request patterns into spi_bus_arbiter. A behavioural model
// stands in for the SPI engine. Expected grants and done pulses go into
// scoreboard queues. A negedge monitor pops and compares them whenever the DUT
// presents a grant or a done pulse.
// -----------------------------------------------------------------------------
module tb_spi_bus_arbiter;

    logic       clk_in = 1'b0;
    logic       rst_n;
    logic [2:0] req;
    logic [2:0] grant;
    logic [2:0] done;
    logic [1:0] sel;
    logic       spi_start;
    logic       spi_done_in;
    logic       spi_cs_in;
    logic [2:0] cs_out;
    logic       busy;
    logic       timeout_err;

    int n_checks = 0;
    int n_errors = 0;
    int starts   = 0;
    int dones    = 0;

    // Engine model: 0 = pulse done, 1 = hold done high, 2 = never finish.
    int eng_mode  = 0;
    int eng_delay = 40;

    logic [2:0] exp_grant_q[$];
    logic [3:0] exp_done_q[$];
    logic [2:0] grant_prev = 3'b000;

    always #5 clk_in = ~clk_in;

    spi_bus_arbiter #(
        .N_REQ          (3),
        .TIMEOUT_CYCLES (24'd100),
        .SYNC_STAGES    (2)
    ) dut (
        .clk_in      (clk_in),
        .rst_n       (rst_n),
        .req         (req),
        .grant       (grant),
        .done        (done),
        .sel         (sel),
        .spi_start   (spi_start),
        .spi_done_in (spi_done_in),
        .spi_cs_in   (spi_cs_in),
        .cs_out      (cs_out),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk_in);
            #1;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_grant"}, {29'd0, grant}, 32'd0);
        check({tag, "_done"}, {29'd0, done}, 32'd0);
        check({tag, "_sel"}, {30'd0, sel}, 32'd0);
        check({tag, "_spi_start"}, {31'd0, spi_start}, 32'd0);
        check({tag, "_cs_out"}, {29'd0, cs_out}, 32'd7);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_timeout_err"}, {31'd0, timeout_err}, 32'd0);
    endtask

    // Ticks until done is seen or the bound runs out.
    task automatic wait_done(input int limit, output int n);
        n = 0;
        while (done === 3'b000 && n < limit) begin
            tick();
            n++;
        end
        check("done_arrived", {31'd0, (done !== 3'b000)}, 32'd1);
    endtask

    task automatic wait_start(input int limit);
        int n;
        n = 0;
        while (spi_start !== 1'b1 && n < limit) begin
            tick();
            n++;
        end
        check("start_arrived", {31'd0, spi_start}, 32'd1);
    endtask

    // SPI engine stand-in.
    initial begin
        spi_done_in = 1'b0;
        spi_cs_in   = 1'b1;
        forever begin
            @(posedge clk_in);
            #1;
            if (spi_start === 1'b1 && eng_mode != 2) begin
                spi_cs_in = 1'b0;
                if (spi_done_in) begin
                    tick(10);
                    spi_done_in = 1'b0;
                    tick(eng_delay - 10);
                end else begin
                    tick(eng_delay);
                end
                spi_cs_in   = 1'b1;
                spi_done_in = 1'b1;
                if (eng_mode == 0) begin
                    tick(3);
                    spi_done_in = 1'b0;
                end
            end
        end
    end

    // Scoreboard monitor.
    always @(negedge clk_in) begin
        if (rst_n === 1'b1) begin
            if (spi_start === 1'b1) starts++;
            if (grant !== 3'b000 && grant_prev === 3'b000) begin
                if (exp_grant_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL grant_unexpected: got %b, expected none", grant);
                end else begin
                    check("grant_order", {29'd0, grant}, {29'd0, exp_grant_q.pop_front()});
                end
            end
            if (!$onehot0(grant)) begin
                n_checks++;
                n_errors++;
                $display("FAIL grant_onehot: got %b, expected at most one bit", grant);
            end
            if (done !== 3'b000) begin
                dones++;
                if (exp_done_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL done_unexpected: got %b/%b, expected none",
                             timeout_err, done);
                end else begin
                    check("done_value", {28'd0, timeout_err, done},
                          {28'd0, exp_done_q.pop_front()});
                end
            end else if (timeout_err !== 1'b0) begin
                n_checks++;
                n_errors++;
                $display("FAIL timeout_err_alone: got %b, expected 0", timeout_err);
            end
        end
        grant_prev = grant;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst_n = 1'b0;
        req   = 3'b000;

        // Test 1: reset values, then a single request with latency checks.
        tick(3);
        check_reset_vals("rst");
        rst_n     = 1'b1;
        eng_mode  = 0;
        eng_delay = 40;
        req       = 3'b001;
        exp_grant_q.push_back(3'b001);
        exp_done_q.push_back(4'b0001);
        tick();
        check("t1_grant_c1", {29'd0, grant}, 32'd1);
        check("t1_busy_c1", {31'd0, busy}, 32'd1);
        tick();
        check("t1_start_c2", {31'd0, spi_start}, 32'd0);
        tick();
        check("t1_start_c3", {31'd0, spi_start}, 32'd1);
        tick(7);
        check("t1_cs_owner", {29'd0, cs_out}, 32'd6);
        wait_done(200, n);
        check("t1_done_latency", n, 32'd37);
        req = 3'b000;
        tick();
        check("t1_cs_after", {29'd0, cs_out}, 32'd7);
        check("t1_grant_after", {29'd0, grant}, 32'd0);
        check("t1_busy_after", {31'd0, busy}, 32'd0);

        // Test 2: all three requesters held high, from a fresh reset.
        rst_n = 1'b0;
        tick(2);
        rst_n     = 1'b1;
        eng_delay = 10;
        req       = 3'b111;
        exp_grant_q.push_back(3'b001);
        exp_grant_q.push_back(3'b010);
        exp_grant_q.push_back(3'b100);
        exp_grant_q.push_back(3'b001);
        exp_done_q.push_back(4'b0001);
        exp_done_q.push_back(4'b0010);
        exp_done_q.push_back(4'b0100);
        exp_done_q.push_back(4'b0001);
        for (int t = 0; t < 4; t++) begin
            wait_done(100, n);
            if (t == 3) req = 3'b000;
            tick();
            check("t2_gap_idle", {31'd0, busy}, 32'd0);
        end
        check("t2_starts", starts, 32'd5);

        // Test 3: engine done left high across the next START.
        eng_mode  = 1;
        eng_delay = 20;
        req       = 3'b010;
        exp_grant_q.push_back(3'b010);
        exp_done_q.push_back(4'b0010);
        wait_done(100, n);
        check("t3_first_latency", n, 32'd27);
        req = 3'b000;
        tick();
        req = 3'b100;
        exp_grant_q.push_back(3'b100);
        exp_done_q.push_back(4'b0100);
        wait_done(100, n);
        check("t3_hold_latency", n, 32'd27);
        req = 3'b000;
        tick();
        check("t3_starts", starts, 32'd7);
        check("t3_done_eq_start", dones, starts);

        // Test 4: asynchronous reset in WAIT while requester 2 owns the bus.
        eng_mode  = 0;
        eng_delay = 40;
        req       = 3'b100;
        exp_grant_q.push_back(3'b100);
        wait_start(10);
        tick(5);
        check("t4_grant_wait", {29'd0, grant}, 32'd4);
        rst_n = 1'b0;
        req   = 3'b000;
        #1;
        check_reset_vals("t4");
        tick(5);
        rst_n = 1'b1;
        tick(50);
        check("t4_stale_busy", {31'd0, busy}, 32'd0);
        req = 3'b110;
        exp_grant_q.push_back(3'b010);
        exp_done_q.push_back(4'b0010);
        wait_done(100, n);
        check("t4_after_rst_latency", n, 32'd47);
        req = 3'b100;
        exp_grant_q.push_back(3'b100);
        exp_done_q.push_back(4'b0100);
        tick();
        wait_done(100, n);
        req = 3'b000;
        tick();

        // Test 5: requester 1 drops req mid-transfer.
        eng_delay = 20;
        req       = 3'b010;
        exp_grant_q.push_back(3'b010);
        exp_done_q.push_back(4'b0010);
        exp_grant_q.push_back(3'b001);
        exp_done_q.push_back(4'b0001);
        tick();
        check("t5_grant", {29'd0, grant}, 32'd2);
        tick(3);
        req = 3'b001;
        wait_done(100, n);
        tick();
        wait_done(100, n);
        req = 3'b000;
        tick(10);
        check("t5_no_regrant", {31'd0, busy}, 32'd0);

        // Test 6: the engine never finishes.
        eng_mode = 2;
        req      = 3'b110;
        exp_grant_q.push_back(3'b010);
        wait_start(10);
`ifdef SPI_BUS_ARBITER_TIMEOUT_EN
        exp_done_q.push_back(4'b1010);
        wait_done(200, n);
        check("t6_timeout_latency", n, 32'd100);
        check("t6_timeout_err", {31'd0, timeout_err}, 32'd1);
        eng_mode = 0;
        req      = 3'b100;
        exp_grant_q.push_back(3'b100);
        exp_done_q.push_back(4'b0100);
        tick();
        wait_done(100, n);
        check("t6_next_no_timeout", {31'd0, timeout_err}, 32'd0);
        req = 3'b000;
        tick();
`else
        tick(10000);
        check("t6_still_busy", {31'd0, busy}, 32'd1);
        check("t6_still_grant", {29'd0, grant}, 32'd2);
        check("t6_no_timeout_err", {31'd0, timeout_err}, 32'd0);
        rst_n = 1'b0;
        req   = 3'b000;
        tick(2);
        rst_n    = 1'b1;
        eng_mode = 0;
        tick(2);
`endif

        check("sb_grant_empty", exp_grant_q.size(), 32'd0);
        check("sb_done_empty", exp_done_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
